row_vector_feeder: RTL and testbench
====================================

// Module: row_vector_feeder
// PURPOSE
//  Drives the row-by-vector dot-product unit for a full matrix-vector product.
//  Fetches per-row chunk counts and 8-element A-row / p-vector chunks from sync-read memories.
//  Issues the start / you_can_read handshake, captures each row result on decoder_read_now
//  and writes it to the result memory at the row index.
// PARAMETERS
//  no_of_elements_in_p_emap_output  8   elements per chunk
//  element_width                    32  bits per element
//  multiples_memory_value_width     3   width of per-row chunk count
//  no_of_rows                       64  rows per matrix
//  row_addr_width                   6   clog2(no_of_rows)
//  a_addr_width                     9   A-chunk memory address width
// PORTS
//  clk               in   1        clock, all logic on posedge
//  reset             in   1        asynchronous, active-low; 0 = reset
//  start             in   1        1-cycle pulse: begin matrix-vector op
//  mult_mem_addr     out  RAW      row index into chunk-count memory
//  mult_mem_data     in   MMW      chunk count for that row (1-cycle read latency)
//  a_mem_addr        out  AAW      linear A-chunk address
//  a_mem_data        in   N*EW     A chunk (1-cycle read latency)
//  p_mem_addr        out  MMW      p-chunk index within row
//  p_mem_data        in   N*EW     p chunk (1-cycle read latency)
//  a, p              out  N*EW     chunk presented to row unit
//  no_of_multiples   out  MMW      chunk count of current row, stable from start_row_by_vector to result capture
//  start_row_by_vector out 1       1-cycle pulse per row
//  you_can_read      out  1        1-cycle pulse: a/p valid this cycle
//  I_am_ready        in   1        row unit can accept a chunk
//  decoder_read_now  in   1        row result valid this cycle
//  result            in   EW       row dot-product result
//  res_we / res_addr / res_data  out 1/RAW/EW  result-memory write port
//  busy, done, error out  1        status; done = 1-cycle pulse, error is sticky
// BEHAVIOUR
//  Reset (reset=0, async): state IDLE; all outputs, counters and pointers 0; error cleared.
//  States: IDLE -> FETCH_CNT -> START_ROW -> FETCH_CHUNK -> PRESENT -> WAIT_RES -> WRITE -> (FETCH_CNT | DONE) -> IDLE.
//  IDLE:        busy=0; start=1 -> row=0, a_ptr=0, go FETCH_CNT. Start while busy is ignored.
//  FETCH_CNT:   mult_mem_addr=row; next cycle latch count into no_of_multiples.
//               If count==0: write res_data=0 for this row directly (WRITE), no row-unit handshake.
//  START_ROW:   start_row_by_vector=1 for exactly one cycle; k=0.
//  FETCH_CHUNK: wait for I_am_ready=1; then drive a_mem_addr=a_ptr, p_mem_addr=k.
//  PRESENT:     one cycle later, register mem data onto a/p; you_can_read=1 for that one cycle;
//               a_ptr++, k++. If k<count -> FETCH_CHUNK, else WAIT_RES.
//  WAIT_RES:    on decoder_read_now=1 capture result -> WRITE. No timeout.
//  WRITE:       res_we=1 for one cycle, res_addr=row, res_data=captured value.
//               row==no_of_rows-1 -> DONE, else row++ -> FETCH_CNT.
//  DONE:        done=1 for one cycle, busy drops the same cycle, back to IDLE.
//  Pointers:    a_ptr wraps mod 2^a_addr_width silently; it is not reset between rows (rows packed contiguously).
//  Protocol errors:
//   - decoder_read_now outside WAIT_RES sets error=1 (sticky until reset); the pulse is otherwise ignored.
//   - decoder_read_now in the same cycle as the final you_can_read is treated as an error.
//  a/p hold their last value between pulses; no_of_multiples changes only in FETCH_CNT.
//  Minimum row latency with I_am_ready held 1: 3 + 2*count cycles + row-unit latency + 1 write cycle.
// TESTING
//  1. Reset low mid-row (state PRESENT) -> next edge: all outputs 0, IDLE; start afterwards runs a clean full pass.
//  2. All counts=1, I_am_ready=1, row unit returns row index -> 64 writes, res_mem[r]=r, a_ptr ends at 64, one done pulse.
//  3. Row 5 count=3 -> three you_can_read pulses with a_mem_addr consecutive and p_mem_addr 0,1,2; single write at res_addr=5.
//  4. Row 2 count=0 -> no start_row_by_vector for row 2; res_mem[2]=0; a_ptr unchanged.
//  5. I_am_ready held low 10 cycles in FETCH_CHUNK -> no you_can_read, a/p stable; resumes 2 cycles after ready rises.
//  6. Spurious decoder_read_now in FETCH_CNT -> error=1 and stays 1; result writes unaffected; start during busy ignored.

Source files
------------

// File: rtl/row_vector_feeder_if.sv
// Bus bundle between the row/vector feeder, its source memories, the row
// dot-product unit and the result memory.
interface row_vector_feeder_if #(
   parameter int N   = 8,
   parameter int EW  = 32,
   parameter int MMW = 3,
   parameter int RAW = 6,
   parameter int AAW = 9
) ();
   logic             start;
   logic [RAW-1:0]   mult_mem_addr;
   logic [MMW-1:0]   mult_mem_data;
   logic [AAW-1:0]   a_mem_addr;
   logic [N*EW-1:0]  a_mem_data;
   logic [MMW-1:0]   p_mem_addr;
   logic [N*EW-1:0]  p_mem_data;
   logic [N*EW-1:0]  a;
   logic [N*EW-1:0]  p;
   logic [MMW-1:0]   no_of_multiples;
   logic             start_row_by_vector;
   logic             you_can_read;
   logic             I_am_ready;
   logic             decoder_read_now;
   logic [EW-1:0]    result;
   logic             res_we;
   logic [RAW-1:0]   res_addr;
   logic [EW-1:0]    res_data;
   logic             busy;
   logic             done;
   logic             error;

   modport master (
      input  start, mult_mem_data, a_mem_data, p_mem_data, I_am_ready,
             decoder_read_now, result,
      output mult_mem_addr, a_mem_addr, p_mem_addr, a, p, no_of_multiples,
             start_row_by_vector, you_can_read, res_we, res_addr, res_data,
             busy, done, error
   );

   modport slave (
      output start, mult_mem_data, a_mem_data, p_mem_data, I_am_ready,
             decoder_read_now, result,
      input  mult_mem_addr, a_mem_addr, p_mem_addr, a, p, no_of_multiples,
             start_row_by_vector, you_can_read, res_we, res_addr, res_data,
             busy, done, error
   );
endinterface

// File: rtl/row_vector_feeder.sv
// Sequences a full matrix-vector product through the row dot-product unit,
// one row at a time, and writes each row result into the result memory.
//
// state       | meaning
// IDLE        | waiting for start
// FETCH_CNT   | two cycles: address chunk-count memory, then latch count
// START_ROW   | one-cycle start pulse to the row unit
// FETCH_CHUNK | wait for I_am_ready, address A/p chunk memories
// PRESENT     | register chunk data; you_can_read fires the following cycle
// WAIT_RES    | wait for decoder_read_now, capture result
// WRITE       | write captured result at the row index
// DONE        | one-cycle done pulse
module row_vector_feeder #(
   parameter int no_of_elements_in_p_emap_output = 8,
   parameter int element_width                   = 32,
   parameter int multiples_memory_value_width    = 3,
   parameter int no_of_rows                      = 64,
   parameter int row_addr_width                  = 6,
   parameter int a_addr_width                    = 9
) (
   input  logic                 clk,
   input  logic                 reset,
   row_vector_feeder_if.master  bus
);
   localparam int N   = no_of_elements_in_p_emap_output;
   localparam int EW  = element_width;
   localparam int MMW = multiples_memory_value_width;
   localparam int RAW = row_addr_width;
   localparam int AAW = a_addr_width;

   localparam logic [2:0] S_IDLE        = 3'd0;
   localparam logic [2:0] S_FETCH_CNT   = 3'd1;
   localparam logic [2:0] S_START_ROW   = 3'd2;
   localparam logic [2:0] S_FETCH_CHUNK = 3'd3;
   localparam logic [2:0] S_PRESENT     = 3'd4;
   localparam logic [2:0] S_WAIT_RES    = 3'd5;
   localparam logic [2:0] S_WRITE       = 3'd6;
   localparam logic [2:0] S_DONE        = 3'd7;

   logic [2:0]      state_q,    state_d;
   logic            cnt_ph_q,   cnt_ph_d;
   logic [RAW-1:0]  row_q,      row_d;
   logic [AAW-1:0]  a_ptr_q,    a_ptr_d;
   logic [MMW-1:0]  k_q,        k_d;
   logic [MMW-1:0]  nom_q,      nom_d;
   logic [N*EW-1:0] a_q,        a_d;
   logic [N*EW-1:0] p_q,        p_d;
   logic            ycr_q,      ycr_d;
   logic [EW-1:0]   res_data_q, res_data_d;
   logic            error_q,    error_d;
   logic [MMW:0]    k_inc;

   assign k_inc = {1'b0, k_q} + (MMW+1)'(1);

   always_comb begin
      state_d    = state_q;
      cnt_ph_d   = cnt_ph_q;
      row_d      = row_q;
      a_ptr_d    = a_ptr_q;
      k_d        = k_q;
      nom_d      = nom_q;
      a_d        = a_q;
      p_d        = p_q;
      ycr_d      = 1'b0;
      res_data_d = res_data_q;
      error_d    = error_q;

      // A result strobe is only legal in WAIT_RES and not on the last chunk's strobe cycle.
      if (bus.decoder_read_now && ((state_q != S_WAIT_RES) || ycr_q))
         error_d = 1'b1;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               row_d    = '0;
               a_ptr_d  = '0;
               cnt_ph_d = 1'b0;
               state_d  = S_FETCH_CNT;
            end
         end
         S_FETCH_CNT: begin
            if (!cnt_ph_q) begin
               cnt_ph_d = 1'b1;
            end else begin
               cnt_ph_d = 1'b0;
               nom_d    = bus.mult_mem_data;
               if (bus.mult_mem_data == '0) begin
                  res_data_d = '0;
                  state_d    = S_WRITE;
               end else begin
                  state_d = S_START_ROW;
               end
            end
         end
         S_START_ROW: begin
            k_d     = '0;
            state_d = S_FETCH_CHUNK;
         end
         S_FETCH_CHUNK: begin
            if (bus.I_am_ready)
               state_d = S_PRESENT;
         end
         S_PRESENT: begin
            a_d     = bus.a_mem_data;
            p_d     = bus.p_mem_data;
            ycr_d   = 1'b1;
            a_ptr_d = a_ptr_q + AAW'(1);
            k_d     = k_inc[MMW-1:0];
            if (k_inc < {1'b0, nom_q})
               state_d = S_FETCH_CHUNK;
            else
               state_d = S_WAIT_RES;
         end
         S_WAIT_RES: begin
            if (bus.decoder_read_now && !ycr_q) begin
               res_data_d = bus.result;
               state_d    = S_WRITE;
            end
         end
         S_WRITE: begin
            if (row_q == RAW'(no_of_rows - 1)) begin
               state_d = S_DONE;
            end else begin
               row_d    = row_q + RAW'(1);
               cnt_ph_d = 1'b0;
               state_d  = S_FETCH_CNT;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         cnt_ph_q   <= 1'b0;
         row_q      <= '0;
         a_ptr_q    <= '0;
         k_q        <= '0;
         nom_q      <= '0;
         a_q        <= '0;
         p_q        <= '0;
         ycr_q      <= 1'b0;
         res_data_q <= '0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_ph_q   <= cnt_ph_d;
         row_q      <= row_d;
         a_ptr_q    <= a_ptr_d;
         k_q        <= k_d;
         nom_q      <= nom_d;
         a_q        <= a_d;
         p_q        <= p_d;
         ycr_q      <= ycr_d;
         res_data_q <= res_data_d;
         error_q    <= error_d;
      end
   end

   assign bus.mult_mem_addr       = row_q;
   assign bus.a_mem_addr          = a_ptr_q;
   assign bus.p_mem_addr          = k_q;
   assign bus.a                   = a_q;
   assign bus.p                   = p_q;
   assign bus.no_of_multiples     = nom_q;
   assign bus.start_row_by_vector = (state_q == S_START_ROW);
   assign bus.you_can_read        = ycr_q;
   assign bus.res_we              = (state_q == S_WRITE);
   assign bus.res_addr            = row_q;
   assign bus.res_data            = res_data_q;
   assign bus.busy                = (state_q != S_IDLE) && (state_q != S_DONE);
   assign bus.done                = (state_q == S_DONE);
   assign bus.error               = error_q;
endmodule

// File: tb/tb_row_vector_feeder.sv
// Directed bench: sync-read memories, a behavioural row unit returning
// (row << 20) + sum of element-0 products' operands, and pass-level checks.
module tb_row_vector_feeder;
   localparam int N = 8, EW = 32, MMW = 3, RAW = 6, AAW = 9, NROWS = 64;
   localparam int STALL_ROW = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   row_vector_feeder_if bus ();
   row_vector_feeder dut (.clk(clk), .reset(reset), .bus(bus));

   int n_checks = 0;
   int n_errors = 0;

   logic [MMW-1:0] cnt_mem  [NROWS];
   logic [EW-1:0]  res_mem  [NROWS];
   logic [EW-1:0]  exp_res  [NROWS];
   bit             start_seen [NROWS];

   int n_wr, n_start, n_ycr, n_done, exp_ptr, k_exp, lat, stall, since_rise, cur_row;
   logic [EW-1:0]   acc;
   logic [N*EW-1:0] snap_a, snap_p;
   bit              pend_spur;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [N*EW-1:0] a_word(input int i);
      logic [N*EW-1:0] w;
      for (int e = 0; e < N; e++) w[e*EW +: EW] = {8'(e), 8'hA5, 16'(i)};
      return w;
   endfunction

   function automatic logic [N*EW-1:0] p_word(input int k);
      logic [N*EW-1:0] w;
      for (int e = 0; e < N; e++) w[e*EW +: EW] = {8'(e), 8'h5C, 16'(k*3+1)};
      return w;
   endfunction

   always @(posedge clk) begin
      bus.mult_mem_data <= cnt_mem[bus.mult_mem_addr];
      bus.a_mem_data    <= a_word(int'(bus.a_mem_addr));
      bus.p_mem_data    <= p_word(int'(bus.p_mem_addr));
   end

   // Behavioural row unit and output monitor, sampling on the falling edge.
   initial begin
      bus.I_am_ready       = 1'b1;
      bus.decoder_read_now = 1'b0;
      bus.result           = '0;
      forever begin
         @(negedge clk);
         bus.decoder_read_now = 1'b0;
         if (!reset) begin
            n_wr = 0; n_start = 0; n_ycr = 0; n_done = 0; exp_ptr = 0; k_exp = 0;
            lat = -1; stall = 0; since_rise = -1; pend_spur = 0; acc = '0; cur_row = 0;
            bus.I_am_ready = 1'b1;
            for (int r = 0; r < NROWS; r++) begin
               start_seen[r] = 1'b0;
               res_mem[r]    = '1;
            end
         end else begin
            if (pend_spur) begin
               chk("error_before_spurious", bus.error, 0);
               bus.decoder_read_now = 1'b1;
               pend_spur = 0;
            end
            if (bus.start_row_by_vector) begin
               cur_row = int'(bus.mult_mem_addr);
               n_start++;
               start_seen[cur_row] = 1'b1;
               chk("nom_at_start", bus.no_of_multiples, cnt_mem[cur_row]);
               k_exp = 0;
               acc   = '0;
               if (cur_row == STALL_ROW) begin
                  bus.I_am_ready = 1'b0;
                  stall  = 10;
                  snap_a = bus.a;
                  snap_p = bus.p;
               end
            end else if (stall > 0) begin
               chk("stall_no_ycr", bus.you_can_read, 0);
               chk("stall_a_stable", bus.a, snap_a);
               chk("stall_p_stable", bus.p, snap_p);
               stall--;
               if (stall == 0) begin
                  bus.I_am_ready = 1'b1;
                  since_rise = 0;
               end
            end else if (since_rise >= 0) begin
               since_rise++;
            end
            if (bus.you_can_read) begin
               n_ycr++;
               chk("chunk_a", bus.a, a_word(exp_ptr));
               chk("chunk_p", bus.p, p_word(k_exp));
               acc = acc + bus.a[EW-1:0] + bus.p[EW-1:0];
               exp_ptr++;
               k_exp++;
               if (since_rise >= 0) begin
                  chk("resume_latency", since_rise, 2);
                  since_rise = -1;
               end
               if (k_exp == int'(cnt_mem[cur_row])) lat = 2;
            end else if (lat > 0) begin
               lat--;
               if (lat == 0) begin
                  bus.decoder_read_now = 1'b1;
                  bus.result = (EW'(cur_row) << 20) + acc;
                  lat = -1;
               end
            end
            if (bus.res_we) begin
               res_mem[bus.res_addr] = bus.res_data;
               n_wr++;
               if (bus.res_addr == 6'd19) pend_spur = 1'b1;
            end
            if (bus.done) n_done++;
         end
      end
   end

   initial begin
      int         base;
      bit         found;
      logic [N*EW-1:0] wa, wp;
      logic [EW-1:0]   s;

      reset     = 1'b0;
      bus.start = 1'b0;
      for (int r = 0; r < NROWS; r++) cnt_mem[r] = 3'd1;
      cnt_mem[2]  = 3'd0;
      cnt_mem[5]  = 3'd3;
      cnt_mem[40] = 3'd7;
      base = 0;
      for (int r = 0; r < NROWS; r++) begin
         if (cnt_mem[r] == 0) begin
            exp_res[r] = '0;
         end else begin
            s = EW'(r) << 20;
            for (int j = 0; j < int'(cnt_mem[r]); j++) begin
               wa = a_word(base + j);
               wp = p_word(j);
               s  = s + wa[EW-1:0] + wp[EW-1:0];
            end
            exp_res[r] = s;
         end
         base += int'(cnt_mem[r]);
      end

      repeat (3) @(negedge clk);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_error", bus.error, 0);
      chk("rst_ycr", bus.you_can_read, 0);
      chk("rst_res_we", bus.res_we, 0);
      chk("rst_a_addr", bus.a_mem_addr, 0);
      reset = 1'b1;

      // First pass, interrupted by reset while row 3 is in PRESENT.
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      found = 0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(negedge clk);
         if (bus.start_row_by_vector && bus.mult_mem_addr == 6'd3) found = 1;
      end
      chk("run1_reach_row3", found, 1);
      @(negedge clk);
      @(negedge clk);
      chk("pre_reset_a_ptr", bus.a_mem_addr, 2);
      chk("pre_reset_busy", bus.busy, 1);
      reset = 1'b0;
      #1;
      chk("midrow_rst_busy", bus.busy, 0);
      chk("midrow_rst_a", bus.a, 0);
      chk("midrow_rst_p", bus.p, 0);
      chk("midrow_rst_a_addr", bus.a_mem_addr, 0);
      chk("midrow_rst_mult_addr", bus.mult_mem_addr, 0);
      chk("midrow_rst_nom", bus.no_of_multiples, 0);
      chk("midrow_rst_ycr", bus.you_can_read, 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Full pass, with a start pulse while busy that must be ignored.
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      repeat (100) @(negedge clk);
      chk("busy_mid_run", bus.busy, 1);
      bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      found = 0;
      for (int i = 0; i < 3000 && !found; i++) begin
         @(negedge clk);
         if (bus.done) found = 1;
      end
      chk("done_seen", found, 1);
      chk("busy_low_with_done", bus.busy, 0);
      repeat (3) @(negedge clk);
      chk("done_pulses", n_done, 1);
      chk("write_count", n_wr, 64);
      chk("start_row_count", n_start, 63);
      chk("ycr_count", n_ycr, 71);
      chk("final_a_ptr", bus.a_mem_addr, 71);
      chk("error_sticky", bus.error, 1);
      chk("row2_no_start", start_seen[2], 0);
      chk("idle_busy", bus.busy, 0);
      for (int r = 0; r < NROWS; r++) chk($sformatf("res_mem[%0d]", r), res_mem[r], exp_res[r]);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
